// File: rtl/overcooked_pkg.sv
// Shared definitions for the kitchen/serving logic.
//   - item codes (ITEM_NONE, DISH_DONE)
//   - slot_state_t : serving-slot state encoding, also exported to the renderer
//   - SPACES / PLAYERS counts, timer width
//   - sat_add8     : 8-bit saturating add of up to two one-bit strobes
package overcooked_pkg;

    localparam int SPACES  = 2;
    localparam int PLAYERS = 2;
    localparam int TIMER_W = 6;

    localparam logic [3:0] ITEM_NONE = 4'd0;
    localparam logic [3:0] DISH_DONE = 4'd4;

    typedef enum logic [2:0] {
        SLOT_EMPTY   = 3'd0,
        SLOT_PRESENT = 3'd1,
        SLOT_WAIT    = 3'd2,
        SLOT_SERVED  = 3'd3,
        SLOT_REJECT  = 3'd4
    } slot_state_t;

    // Both slots can strobe in the same frame, so the counter may step by 2.
    function automatic logic [7:0] sat_add8(input logic [7:0] count, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, count} + 9'(inc[0]) + 9'(inc[1]);
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/serving_window_if.sv
// Bundle between the serving window and its neighbours (players, tracker,
// renderer).
//   place_req/place_space/place_item : per-player drop requests
//   place_ack                        : per-player registered accept
//   clear_space                      : per-space "scored" pulse from the tracker
//   check_spaces                     : per-space item presented for scoring
//   space_items/space_status         : per-space contents and state for rendering
//   served_count/trashed_count       : saturating dish counters
// master = the environment driving requests, slave = serving_window.
interface serving_window_if;
    logic [1:0]      place_req;
    logic [1:0]      place_space;
    logic [1:0][3:0] place_item;
    logic [1:0]      place_ack;
    logic [1:0]      clear_space;
    logic [1:0][3:0] check_spaces;
    logic [1:0][3:0] space_items;
    logic [1:0][2:0] space_status;
    logic [7:0]      served_count;
    logic [7:0]      trashed_count;

    modport master (
        output place_req, place_space, place_item, clear_space,
        input  place_ack, check_spaces, space_items, space_status,
               served_count, trashed_count
    );

    modport slave (
        input  place_req, place_space, place_item, clear_space,
        output place_ack, check_spaces, space_items, space_status,
               served_count, trashed_count
    );
endinterface

// File: rtl/serving_slot.sv
// One serving-counter space: state machine, frame timer and item register.
//   vsync       : frame clock, state changes on the falling edge
//   clr         : synchronous clear (reset or menu)
//   place_en    : arbitrated drop into this slot (only raised while EMPTY)
//   place_item  : item being dropped
//   clear_in    : tracker acknowledge; only honoured in WAIT
//   state/item  : current slot state and stored item
//   check       : item while PRESENT, else 0
//   served_stb  : one-cycle strobe on WAIT -> SERVED
//   trashed_stb : one-cycle strobe on REJECT -> EMPTY
//
// state   | meaning
// EMPTY   | nothing on the counter, accepts a drop
// PRESENT | finished dish shown to the tracker for exactly one frame
// WAIT    | waiting ACK_FRAMES frames for clear_in, then re-present
// SERVED  | dish scored, flash shown for SERVE_FRAMES frames
// REJECT  | wrong item, trashed after REJECT_FRAMES frames
module serving_slot
    import overcooked_pkg::*;
#(
    parameter logic [3:0] DISH_CODE     = DISH_DONE,
    parameter int         ACK_FRAMES    = 3,
    parameter int         SERVE_FRAMES  = 30,
    parameter int         REJECT_FRAMES = 45
) (
    input  logic        vsync,
    input  logic        clr,
    input  logic        place_en,
    input  logic [3:0]  place_item,
    input  logic        clear_in,
    output slot_state_t state,
    output logic [3:0]  item,
    output logic [3:0]  check,
    output logic        served_stb,
    output logic        trashed_stb
);

    if (ACK_FRAMES < 1 || ACK_FRAMES > 63 || SERVE_FRAMES < 1 || SERVE_FRAMES > 63 ||
        REJECT_FRAMES < 1 || REJECT_FRAMES > 63) begin : g_bad_timer
        $error("serving_slot: frame counts must be within 1..63");
    end

    localparam logic [TIMER_W-1:0] ACK_T    = TIMER_W'(ACK_FRAMES);
    localparam logic [TIMER_W-1:0] SERVE_T  = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] REJECT_T = TIMER_W'(REJECT_FRAMES);

    slot_state_t        state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [3:0]         item_nx;
    logic               timer_tc;

    // Loaded with N, the state lasts N frames: the exit edge is the one that sees 1.
    assign timer_tc = (timer == TIMER_W'(1));

    always_ff @(negedge vsync) begin
        if (clr) begin
            state <= SLOT_EMPTY;
            timer <= '0;
            item  <= ITEM_NONE;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            item  <= item_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        item_nx     = item;
        served_stb  = 1'b0;
        trashed_stb = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (place_en && place_item != ITEM_NONE) begin
                    item_nx = place_item;
                    if (place_item == DISH_CODE) begin
                        state_nx = SLOT_PRESENT;
                    end else begin
                        state_nx = SLOT_REJECT;
                        timer_nx = REJECT_T;
                    end
                end
            end
            SLOT_PRESENT: begin
                state_nx = SLOT_WAIT;
                timer_nx = ACK_T;
            end
            SLOT_WAIT: begin
                if (clear_in) begin
                    served_stb = 1'b1;
                    state_nx   = SLOT_SERVED;
                    timer_nx   = SERVE_T;
                end else if (timer_tc) begin
                    state_nx = SLOT_PRESENT;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - TIMER_W'(1);
                end
            end
            SLOT_SERVED, SLOT_REJECT: begin
                if (timer_tc) begin
                    trashed_stb = (state == SLOT_REJECT);
                    state_nx    = SLOT_EMPTY;
                    timer_nx    = '0;
                    item_nx     = ITEM_NONE;
                end else begin
                    timer_nx = timer - TIMER_W'(1);
                end
            end
            default: begin
                state_nx = SLOT_EMPTY;
                timer_nx = '0;
                item_nx  = ITEM_NONE;
            end
        endcase
    end

    // Only PRESENT exposes the item, so the tracker sees one frame per presentation.
    assign check = (state == SLOT_PRESENT) ? item : ITEM_NONE;

endmodule

// File: rtl/serving_window.sv
// Serving window: two serving-counter spaces, drop arbitration between the two
// players, and saturating served/trashed counters.
//   vsync      : frame clock, all updates on the falling edge
//   reset      : synchronous active-high clear
//   game_state : 0 (menu) clears everything like reset
//   bus        : serving_window_if slave (placements, tracker handshake, render data)
module serving_window #(
    parameter logic [3:0] DISH_DONE     = overcooked_pkg::DISH_DONE,
    parameter int         ACK_FRAMES    = 3,
    parameter int         SERVE_FRAMES  = 30,
    parameter int         REJECT_FRAMES = 45
) (
    input  logic             vsync,
    input  logic             reset,
    input  logic [2:0]       game_state,
    serving_window_if.slave  bus
);
    import overcooked_pkg::*;

    logic            clr;
    slot_state_t     slot_st [SPACES];
    logic [1:0]      valid, accept;
    logic [1:0]      place_en, served_stb, trashed_stb;
    logic [1:0][3:0] slot_item_in, slot_item, slot_check;

    assign clr = reset || (game_state == 3'd0);

    // A drop is valid against the slot state latched at the start of the frame.
    // Player 0 wins a tie on the same space; write player 1 first so player 0 overrides.
    always_comb begin
        valid        = '0;
        accept       = '0;
        place_en     = '0;
        slot_item_in = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            valid[p] = bus.place_req[p] && (bus.place_item[p] != ITEM_NONE) &&
                       (slot_st[bus.place_space[p]] == SLOT_EMPTY);
        end
        accept[0] = valid[0];
        accept[1] = valid[1] && !(valid[0] && (bus.place_space[0] == bus.place_space[1]));
        for (int s = 0; s < SPACES; s++) begin
            if (accept[1] && bus.place_space[1] == 1'(s)) begin
                place_en[s]     = 1'b1;
                slot_item_in[s] = bus.place_item[1];
            end
            if (accept[0] && bus.place_space[0] == 1'(s)) begin
                place_en[s]     = 1'b1;
                slot_item_in[s] = bus.place_item[0];
            end
        end
    end

    for (genvar s = 0; s < SPACES; s++) begin : g_slot
        serving_slot #(
            .DISH_CODE     (DISH_DONE),
            .ACK_FRAMES    (ACK_FRAMES),
            .SERVE_FRAMES  (SERVE_FRAMES),
            .REJECT_FRAMES (REJECT_FRAMES)
        ) u_slot (
            .vsync       (vsync),
            .clr         (clr),
            .place_en    (place_en[s]),
            .place_item  (slot_item_in[s]),
            .clear_in    (bus.clear_space[s]),
            .state       (slot_st[s]),
            .item        (slot_item[s]),
            .check       (slot_check[s]),
            .served_stb  (served_stb[s]),
            .trashed_stb (trashed_stb[s])
        );
    end

    always_ff @(negedge vsync) begin
        if (clr) begin
            bus.place_ack     <= '0;
            bus.served_count  <= '0;
            bus.trashed_count <= '0;
        end else begin
            bus.place_ack     <= accept;
            bus.served_count  <= sat_add8(bus.served_count, served_stb);
            bus.trashed_count <= sat_add8(bus.trashed_count, trashed_stb);
        end
    end

    always_comb begin
        bus.check_spaces = slot_check;
        bus.space_items  = slot_item;
        bus.space_status = '0;
        for (int s = 0; s < SPACES; s++) begin
            bus.space_status[s] = slot_st[s];
        end
    end

endmodule
